// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: groups the instruction-memory, redirect and decode
// signals of the fetch stage.
//   master : fetch unit side (drives imem_req/imem_addr and the decode outputs)
//   slave  : environment side (memory, branch unit, decode)
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            decode_ready;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            opcode_31;
  logic [3:0]      funct_IF;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    input  redirect_valid, redirect_pc,
    input  decode_ready,
    output instr_valid, instr, instr_pc, opcode_31, funct_IF
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    output redirect_valid, redirect_pc,
    output decode_ready,
    input  instr_valid, instr, instr_pc, opcode_31, funct_IF
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, single-outstanding instruction fetch and
// a 2-entry {pc, instr} buffer feeding decode. Redirects flush the buffer and
// discard any in-flight response.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_unit_if.master (imem request/response, redirect,
//           decode handshake and head-instruction outputs)
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE         | no fetch outstanding; request issues when buffer has room
// WAIT         | fetch outstanding; its response will be buffered
// WAIT_DISCARD | fetch outstanding but stale (redirected); response dropped
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [1:0]      count;
  logic            head, tail;
  logic [XLEN-1:0] buf_pc    [2];
  logic [31:0]     buf_instr [2];

  logic            req, push, pop, head_valid;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;

  assign head_valid = (count != 2'd0);

  // rst_n gate keeps the request low while reset is held, even though the
  // reset state (IDLE, empty buffer) would otherwise request.
  assign req  = rst_n && (state == IDLE) && (count != 2'd2) && !bus.redirect_valid;
  assign push = (state == WAIT) && bus.imem_valid && !bus.redirect_valid;
  assign pop  = head_valid && bus.decode_ready && !bus.redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: begin
        if (bus.redirect_valid) state_nxt = bus.imem_valid ? IDLE : WAIT_DISCARD;
        else if (bus.imem_valid) state_nxt = IDLE;
      end
      WAIT_DISCARD: if (bus.imem_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      count        <= 2'd0;
      head         <= 1'b0;
      tail         <= 1'b0;
      buf_pc[0]    <= '0;
      buf_pc[1]    <= '0;
      buf_instr[0] <= '0;
      buf_instr[1] <= '0;
    end else if (bus.redirect_valid) begin
      pc    <= bus.redirect_pc & ~XLEN'(3);
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        buf_pc[tail]    <= pc;
        buf_instr[tail] <= bus.imem_rdata;
        tail            <= ~tail;
        pc              <= pc + XLEN'(4);
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_instr = head_valid ? buf_instr[head] : 32'd0;
  assign head_pc    = head_valid ? buf_pc[head]    : '0;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_instr;
  assign bus.instr_pc    = head_pc;
  assign bus.opcode_31   = head_instr[31];
  assign bus.funct_IF    = {head_instr[30], head_instr[14:12]};

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-cycle RISC-V core, placed directly upstream of the control unit and decoder. It holds the program counter and issues word fetches to instruction memory with one request outstanding at most. Returned words go into a 2-entry buffer, and the head entry is presented to decode together with the pre-extracted `opcode_31` and `funct_IF` fields. Control-flow redirects flush the buffer and drop any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `XLEN`, default 32: PC and instruction width; only 32 is supported.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `imem_req`, out, 1: fetch request; one-cycle pulse, always accepted by memory.
- `imem_addr`, out, XLEN: word-aligned fetch address, valid when `imem_req`=1.
- `imem_valid`, in, 1: response strobe, at least 1 cycle after the request.
- `imem_rdata`, in, 32: instruction word, valid with `imem_valid`.
- `redirect_valid`, in, 1: branch/jump redirect, single-cycle pulse.
- `redirect_pc`, in, XLEN: redirect target; bits [1:0] are ignored and forced to 0.
- `decode_ready`, in, 1: decode accepts the head instruction this cycle.
- `instr_valid`, out, 1: buffer head is valid.
- `instr`, out, 32: buffer head instruction.
- `instr_pc`, out, XLEN: PC of the head instruction.
- `opcode_31`, out, 1: equals `instr[31]`.
- `funct_IF`, out, 4: equals {`instr[30]`, `instr[14:12]`}.

## Operation
- State machine with three states: IDLE, WAIT, WAIT_DISCARD.
- Registers: `pc`, `state`, buffer `count` (0..2), plus head/tail pointers over 2 entries of {pc, instr}.
- IDLE:
  - `imem_req` = (`count` < 2) and not `redirect_valid`; `imem_addr` = `pc`.
  - When a request issues, go to WAIT.
- WAIT:
  - On `imem_valid`: push {`pc`, `imem_rdata`}, set `pc` <= `pc` + 4 (wraps modulo 2^32), go to IDLE.
- WAIT_DISCARD:
  - On `imem_valid`: drop the data, `pc` unchanged, go to IDLE.
- `imem_req` is never asserted in WAIT or WAIT_DISCARD, so at most one request is outstanding.
- Pop: when `instr_valid` and `decode_ready`, advance the head and decrement `count`.
- Push and pop in the same cycle leave `count` unchanged.
- Overflow cannot occur: a request issues only when `count` < 2, and `count` can rise only through that request's push.
- Redirect has priority over push, pop and request:
  - `count` <= 0, pointers cleared, `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - In WAIT without `imem_valid` in the same cycle: go to WAIT_DISCARD.
  - In WAIT with `imem_valid` in the same cycle: drop the response, go to IDLE.
  - In WAIT_DISCARD: stay there, or go to IDLE if `imem_valid` arrives in the same cycle; `pc` takes the latest target.
  - In IDLE: no request that cycle; stay in IDLE.
- Output derivation: `instr_valid` = (`count` != 0); `instr`, `instr_pc`, `opcode_31` and `funct_IF` are driven combinationally from the head entry.
- When `instr_valid`=0, `instr`, `instr_pc`, `opcode_31` and `funct_IF` are 0.

## Timing
- Reset (asynchronous on `rst_n` low):
  - `pc` = RESET_PC, state = IDLE, `count` = 0.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, `opcode_31`=0, `funct_IF`=0.
  - `imem_req` is forced to 0 while `rst_n`=0.
- First request: `imem_req`=1 with `imem_addr`=RESET_PC in the first cycle after `rst_n` deasserts.
- Latency: a response in cycle N gives `instr_valid`=1 in cycle N+1.
- Next request in cycle N+1 if `count` < 2 after that edge.
- Throughput with 1-cycle memory: one instruction per 2 cycles.
- Stall: `decode_ready`=0 holds the head stable. After two pushes, `imem_req` stays low until a pop.
- Redirect in cycle R:
  - `instr_valid`=0 in cycle R+1.
  - If in IDLE: the request to the target issues in R+1.
  - If in WAIT: the request to the target issues in the cycle after the stale response arrives.
- Reset asserted mid-operation: immediate return to reset values. Any response arriving later while in IDLE is ignored.

## Test plan
- Reset, then 1-cycle memory returning addr+32'h100:
  - `imem_addr` sequence 0x0, 0x4, 0x8.
  - `instr`/`instr_pc` pairs (0x100,0x0), (0x104,0x4).
  - `instr_valid` first high 2 cycles after reset release.
- `decode_ready`=0 with 3-cycle memory latency:
  - Buffer fills with PCs 0x0 and 0x4, then `imem_req` stays 0.
  - Raising `decode_ready` for one cycle pops 0x0, and the next request to 0x8 issues the following cycle.
- Field extraction: `imem_rdata`=32'h4000_5033 (funct7[5]=1, funct3=101, bit31=0) -> `opcode_31`=0, `funct_IF`=4'b1101. `imem_rdata`=32'h8000_0000 -> `opcode_31`=1, `funct_IF`=0.
- Redirect to 0x203 while in WAIT, with the response 2 cycles later:
  - Response dropped, `instr_valid`=0 throughout.
  - Next `imem_addr`=0x200 the cycle after the stale response.
  - First delivered `instr_pc`=0x200.
- Redirect in the same cycle as `imem_valid`: data not buffered, state IDLE, request to the target issues the next cycle. A second redirect to 0x300 during WAIT_DISCARD means the first fetch is to 0x300.
- `pc`=0xFFFF_FFFC fetch completes: the next `imem_addr`=0x0000_0000 (wrap). Reset pulsed mid-WAIT -> outputs 0 immediately, first request to RESET_PC after release.
